// File: rtl/bp_pkg.sv
// Shared types and constants for the local branch predictor with checkpoint queue.
package bp_pkg;

    // Controller states: table sweep after reset, normal operation, history rollback.
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPAIR = 2'd2
    } bp_state_e;

    // Weakly-not-taken value a counter holds after the sweep.
    function automatic int cnt_init(input int cnt_w);
        return (32'sd1 <<< (cnt_w - 32'sd1)) - 32'sd1;
    endfunction

    // Upper saturation limit of a counter.
    function automatic int cnt_max(input int cnt_w);
        return (32'sd1 <<< cnt_w) - 32'sd1;
    endfunction

    // Checkpoint entry layout is {index, history, prediction}.
    function automatic int ckpt_entry_w(input int index_len, input int history_len);
        return index_len + history_len + 32'sd1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/local_predictor_ckpt_checkpoint_queue.sv
// In-order circular buffer of in-flight predictions: pushes at the head,
// retires the oldest entry at the tail and can unwind the youngest entry.
module checkpoint_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_oldest,
    input  logic                     pop_youngest,
    output logic [WIDTH-1:0]         oldest_data,
    output logic [WIDTH-1:0]         youngest_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [PW-1:0]    young_ptr_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;

    assign young_ptr_s   = head_r - PTR_ONE;
    assign oldest_data   = mem_r[tail_r];
    assign youngest_data = mem_r[young_ptr_s];
    assign count         = count_r;
    assign full          = (count_r == CNT_FULL);
    assign empty         = (count_r == '0);

    // Next occupancy: a push paired with a retire leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (push && !pop_oldest) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_oldest && !push) begin
            count_nxt_s = count_r - CNT_ONE;
        end else if (pop_youngest) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Head/tail pointers and occupancy, wrapping modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                head_r <= head_r + PTR_ONE;
            end else if (pop_youngest) begin
                head_r <= young_ptr_s;
            end else begin
                head_r <= head_r;
            end
            if (pop_oldest) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[head_r] <= push_data;
        end
    end

endmodule

// File: rtl/local_predictor_ckpt.sv
// Two-level local branch predictor: per-PC local history table feeding a
// saturating-counter pattern table, with an internal checkpoint queue that
// carries prediction state to resolve and rolls histories back on mispredict.
module local_predictor_ckpt
    import bp_pkg::*;
#(
    parameter int HISTORY_LEN = 10,
    parameter int INDEX_LEN   = 7,
    parameter int PC_LSB      = 2,
    parameter int CNT_W       = 2,
    parameter int CKPT_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          predict_valid,
    input  logic [15:0]                   predict_pc,
    output logic                          predict_ready,
    output logic                          predict_taken,
    input  logic                          resolve_valid,
    input  logic                          resolve_outcome,
    output logic                          resolve_ready,
    output logic                          resolve_mispredict,
    output logic                          resolve_error,
    output logic                          init_done,
    output logic [$clog2(CKPT_DEPTH):0]   ckpt_count
);
    localparam int EW    = ckpt_entry_w(INDEX_LEN, HISTORY_LEN);
    localparam int SWP_W = max_int(HISTORY_LEN, INDEX_LEN);
    localparam int CW    = $clog2(CKPT_DEPTH) + 1;
    localparam int LHT_N = 1 << INDEX_LEN;
    localparam int PHT_N = 1 << HISTORY_LEN;

    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(cnt_init(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [SWP_W-1:0] SWP_ONE   = SWP_W'(32'd1);
    localparam logic [SWP_W-1:0] SWP_LAST  = '1;
    localparam logic [CW-1:0]    QCNT_ONE  = CW'(32'd1);

    // Counter step toward the resolved direction, holding at either limit.
    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] c, input logic up);
        logic [CNT_W-1:0] r;
        if (up) begin
            r = (c == CNT_MAX) ? c : (c + CNT_ONE);
        end else begin
            r = (c == CNT_ZERO) ? c : (c - CNT_ONE);
        end
        return r;
    endfunction

    bp_state_e              state_r;
    bp_state_e              state_nxt_s;
    logic [SWP_W-1:0]       sweep_ptr_r;
    logic [HISTORY_LEN-1:0] lht_r [LHT_N];
    logic [CNT_W-1:0]       pht_r [PHT_N];

    logic                   run_s;
    logic                   repair_s;
    logic                   sweep_last_s;
    logic                   repair_last_s;

    logic [INDEX_LEN-1:0]   pred_idx_s;
    logic [HISTORY_LEN-1:0] pred_hist_s;
    logic                   predict_taken_s;
    logic                   predict_ready_s;
    logic                   predict_accept_s;
    logic                   resolve_ready_s;
    logic                   resolve_accept_s;
    logic                   mispredict_s;

    logic [EW-1:0]          push_data_s;
    logic [EW-1:0]          old_data_s;
    logic [EW-1:0]          young_data_s;
    logic [INDEX_LEN-1:0]   old_idx_s;
    logic [HISTORY_LEN-1:0] old_hist_s;
    logic                   old_pred_s;
    logic [INDEX_LEN-1:0]   young_idx_s;
    logic [HISTORY_LEN-1:0] young_hist_s;
    logic                   pop_young_s;
    logic                   q_full_s;
    logic                   q_empty_s;
    logic [CW-1:0]          q_count_s;

    logic [CW-1:0]          repair_cnt_r;
    logic [INDEX_LEN-1:0]   rep_idx_r;
    logic [HISTORY_LEN-1:0] rep_hist_r;
    logic                   resolve_error_r;
    logic                   init_done_r;

    logic                   young_pred_unused_s;
    logic                   pc_unused_s;

    // Table lookup for the requesting branch and checkpoint field unpacking.
    always_comb begin
        pred_idx_s          = predict_pc[PC_LSB+INDEX_LEN-1:PC_LSB];
        pred_hist_s         = lht_r[pred_idx_s];
        predict_taken_s     = pht_r[pred_hist_s][CNT_W-1];
        push_data_s         = {pred_idx_s, pred_hist_s, predict_taken_s};
        old_idx_s           = old_data_s[EW-1 -: INDEX_LEN];
        old_hist_s          = old_data_s[HISTORY_LEN:1];
        old_pred_s          = old_data_s[0];
        young_idx_s         = young_data_s[EW-1 -: INDEX_LEN];
        young_hist_s        = young_data_s[HISTORY_LEN:1];
        young_pred_unused_s = young_data_s[0];
        pc_unused_s         = ^predict_pc;
    end

    // Handshakes: a mispredicting resolve blocks the same-cycle predict.
    always_comb begin
        sweep_last_s     = (sweep_ptr_r == SWP_LAST);
        repair_last_s    = (repair_cnt_r == '0);
        resolve_ready_s  = run_s & ~q_empty_s;
        resolve_accept_s = resolve_valid & resolve_ready_s;
        mispredict_s     = resolve_accept_s & (resolve_outcome != old_pred_s);
        predict_ready_s  = run_s & ~q_full_s & ~mispredict_s;
        predict_accept_s = predict_valid & predict_ready_s;
        pop_young_s      = repair_s & ~repair_last_s;
    end

    // State register and INIT sweep pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_INIT;
            sweep_ptr_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_INIT) begin
                sweep_ptr_r <= sweep_ptr_r + SWP_ONE;
            end else begin
                sweep_ptr_r <= sweep_ptr_r;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (sweep_last_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                if (mispredict_s) begin
                    state_nxt_s = ST_REPAIR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_REPAIR: begin
                if (repair_last_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_REPAIR;
                end
            end
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // State decode used by the handshakes and table writes.
    always_comb begin
        run_s    = 1'b0;
        repair_s = 1'b0;
        case (state_r)
            ST_RUN:    run_s    = 1'b1;
            ST_REPAIR: repair_s = 1'b1;
            default: begin
                run_s    = 1'b0;
                repair_s = 1'b0;
            end
        endcase
    end

    // Repair bookkeeping, empty-queue error pulse and the init_done flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            repair_cnt_r    <= '0;
            rep_idx_r       <= '0;
            rep_hist_r      <= '0;
            resolve_error_r <= 1'b0;
            init_done_r     <= 1'b0;
        end else begin
            if (mispredict_s) begin
                repair_cnt_r <= q_count_s - QCNT_ONE;
                rep_idx_r    <= old_idx_s;
                rep_hist_r   <= {old_hist_s[HISTORY_LEN-2:0], resolve_outcome};
            end else if (pop_young_s) begin
                repair_cnt_r <= repair_cnt_r - QCNT_ONE;
            end else begin
                repair_cnt_r <= repair_cnt_r;
            end
            resolve_error_r <= run_s & resolve_valid & q_empty_s;
            init_done_r     <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_REPAIR);
        end
    end

    // Local history table: sweep clear, speculative shift, or rollback.
    always_ff @(posedge clk) begin
        case (state_r)
            ST_INIT: lht_r[sweep_ptr_r[INDEX_LEN-1:0]] <= '0;
            ST_RUN: begin
                if (predict_accept_s) begin
                    lht_r[pred_idx_s] <= {pred_hist_s[HISTORY_LEN-2:0], predict_taken_s};
                end
            end
            ST_REPAIR: begin
                if (!repair_last_s) begin
                    lht_r[young_idx_s] <= young_hist_s;
                end else begin
                    lht_r[rep_idx_r] <= rep_hist_r;
                end
            end
            default: ;
        endcase
    end

    // Pattern history table: sweep to weakly-not-taken, train on resolve.
    always_ff @(posedge clk) begin
        case (state_r)
            ST_INIT: pht_r[sweep_ptr_r[HISTORY_LEN-1:0]] <= CNT_INIT;
            ST_RUN: begin
                if (resolve_accept_s) begin
                    pht_r[old_hist_s] <= sat_update(pht_r[old_hist_s], resolve_outcome);
                end
            end
            default: ;
        endcase
    end

    checkpoint_queue #(
        .DEPTH (CKPT_DEPTH),
        .WIDTH (EW)
    ) u_ckpt_q (
        .clk           (clk),
        .rst_n         (reset),
        .push          (predict_accept_s),
        .push_data     (push_data_s),
        .pop_oldest    (resolve_accept_s),
        .pop_youngest  (pop_young_s),
        .oldest_data   (old_data_s),
        .youngest_data (young_data_s),
        .count         (q_count_s),
        .full          (q_full_s),
        .empty         (q_empty_s)
    );

    assign predict_ready      = predict_ready_s;
    assign predict_taken      = predict_taken_s;
    assign resolve_ready      = resolve_ready_s;
    assign resolve_mispredict = mispredict_s;
    assign resolve_error      = resolve_error_r;
    assign init_done          = init_done_r;
    assign ckpt_count         = q_count_s;

endmodule

// File: tb/tb_local_predictor_ckpt.sv
// Directed bench with a reference model and an in-order scoreboard of
// in-flight predictions for local_predictor_ckpt.
module tb_local_predictor_ckpt;

    typedef struct {
        logic [6:0] idx;
        logic [9:0] h;
        logic       pred;
    } ent_t;

    logic       clk;
    logic       reset;
    logic       predict_valid, resolve_valid, resolve_outcome;
    logic [15:0] predict_pc;
    logic       predict_ready, predict_taken, resolve_ready, resolve_mispredict;
    logic       resolve_error, init_done;
    logic [3:0] ckpt_count;

    logic       pv3, rv3, ro3;
    logic [15:0] pc3;
    logic       pr3, pt3, rr3, rm3, re3, id3;
    logic [3:0] cc3;

    ent_t       sb[$];
    logic [9:0] lht_m [128];
    logic [1:0] pht_m [1024];

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    logic       t, m;
    logic [9:0] pat;

    local_predictor_ckpt dut (
        .clk(clk), .reset(reset),
        .predict_valid(predict_valid), .predict_pc(predict_pc),
        .predict_ready(predict_ready), .predict_taken(predict_taken),
        .resolve_valid(resolve_valid), .resolve_outcome(resolve_outcome),
        .resolve_ready(resolve_ready), .resolve_mispredict(resolve_mispredict),
        .resolve_error(resolve_error), .init_done(init_done), .ckpt_count(ckpt_count)
    );

    local_predictor_ckpt #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset),
        .predict_valid(pv3), .predict_pc(pc3),
        .predict_ready(pr3), .predict_taken(pt3),
        .resolve_valid(rv3), .resolve_outcome(ro3),
        .resolve_ready(rr3), .resolve_mispredict(rm3),
        .resolve_error(re3), .init_done(id3), .ckpt_count(cc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_model();
        for (int i = 0; i < 128; i++) lht_m[i] = 10'd0;
        for (int i = 0; i < 1024; i++) pht_m[i] = 2'd1;
        sb.delete();
    endtask

    task automatic wait_init();
        reset = 1'b1;
        repeat (1023) step();
        chk("init_early", 32'(init_done), 32'd0);
        step();
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_pready", 32'(predict_ready), 32'd1);
        chk("init_done3", 32'(id3), 32'd1);
        init_model();
    endtask

    task automatic do_predict(input logic [15:0] pc, output logic obs_taken);
        ent_t e;
        e.idx = pc[8:2];
        e.h = lht_m[e.idx];
        e.pred = pht_m[e.h][1];
        predict_valid = 1'b1;
        predict_pc = pc;
        #1;
        chk("pred_ready", 32'(predict_ready), 32'd1);
        chk("pred_taken", 32'(predict_taken), 32'(e.pred));
        obs_taken = predict_taken;
        sb.push_back(e);
        lht_m[e.idx] = {e.h[8:0], e.pred};
        step();
        predict_valid = 1'b0;
        chk("pred_count", 32'(ckpt_count), 32'(sb.size()));
    endtask

    task automatic pht_train(input logic [9:0] h, input logic outcome);
        if (outcome && pht_m[h] != 2'd3) pht_m[h] = pht_m[h] + 2'd1;
        else if (!outcome && pht_m[h] != 2'd0) pht_m[h] = pht_m[h] - 2'd1;
    endtask

    task automatic do_resolve(input logic outcome, output logic mis);
        ent_t e;
        int n;
        e = sb.pop_front();
        mis = (outcome != e.pred);
        resolve_valid = 1'b1;
        resolve_outcome = outcome;
        #1;
        chk("res_ready", 32'(resolve_ready), 32'd1);
        chk("res_mis", 32'(resolve_mispredict), 32'(mis));
        if (mis) chk("mis_blocks_pred", 32'(predict_ready), 32'd0);
        pht_train(e.h, outcome);
        step();
        resolve_valid = 1'b0;
        if (mis) begin
            n = sb.size();
            for (int i = n - 1; i >= 0; i--) lht_m[sb[i].idx] = sb[i].h;
            lht_m[e.idx] = {e.h[8:0], outcome};
            sb.delete();
            for (int i = 0; i <= n; i++) begin
                chk("rep_pready", 32'(predict_ready), 32'd0);
                chk("rep_rready", 32'(resolve_ready), 32'd0);
                step();
            end
            chk("rep_exit_ready", 32'(predict_ready), 32'd1);
        end
        chk("res_count", 32'(ckpt_count), 32'(sb.size()));
    endtask

    task automatic do_both(input logic [15:0] pc);
        ent_t e, o;
        o = sb[0];
        e.idx = pc[8:2];
        e.h = lht_m[e.idx];
        e.pred = pht_m[e.h][1];
        predict_valid = 1'b1;
        predict_pc = pc;
        resolve_valid = 1'b1;
        resolve_outcome = o.pred;
        #1;
        chk("both_pready", 32'(predict_ready), 32'd1);
        chk("both_taken", 32'(predict_taken), 32'(e.pred));
        chk("both_rready", 32'(resolve_ready), 32'd1);
        chk("both_mis", 32'(resolve_mispredict), 32'd0);
        void'(sb.pop_front());
        pht_train(o.h, o.pred);
        sb.push_back(e);
        lht_m[e.idx] = {e.h[8:0], e.pred};
        step();
        predict_valid = 1'b0;
        resolve_valid = 1'b0;
        chk("both_count", 32'(ckpt_count), 32'(sb.size()));
    endtask

    initial begin
        reset = 1'b0;
        predict_valid = 1'b0; predict_pc = 16'h0000;
        resolve_valid = 1'b0; resolve_outcome = 1'b0;
        pv3 = 1'b0; pc3 = 16'h0000; rv3 = 1'b0; ro3 = 1'b0;
        repeat (3) step();
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_pready", 32'(predict_ready), 32'd0);
        chk("rst_rready", 32'(resolve_ready), 32'd0);
        chk("rst_count", 32'(ckpt_count), 32'd0);
        chk("rst_err", 32'(resolve_error), 32'd0);
        wait_init();

        // First prediction after the sweep.
        chk("a_count0", 32'(ckpt_count), 32'd0);
        do_predict(16'h0040, t);
        chk("a_taken", 32'(t), 32'd0);
        chk("a_count1", 32'(ckpt_count), 32'd1);
        do_resolve(1'b0, m);

        // Serial always-taken branch trains the history up to all ones.
        for (int k = 0; k < 12; k++) begin
            do_predict(16'h0100, t);
            chk("b_pred", 32'(t), 32'(k == 11));
            do_resolve(1'b1, m);
            chk("b_mis", 32'(m), 32'(k < 11));
            if (k == 10) chk("b_lht", 32'(dut.lht_r[7'h40]), 32'h3FF);
        end
        for (int k = 0; k < 2; k++) begin
            do_predict(16'h0100, t);
            do_resolve(1'b1, m);
        end
        chk("b_sat", 32'(dut.pht_r[10'h3FF]), 32'd3);

        // Full queue blocks predicts; one retire reopens.
        for (int i = 0; i < 8; i++) do_predict(16'h0080 + 16'(4 * i), t);
        chk("c_full_count", 32'(ckpt_count), 32'd8);
        predict_valid = 1'b1;
        predict_pc = 16'h00A0;
        #1;
        chk("c_full_block", 32'(predict_ready), 32'd0);
        step();
        predict_valid = 1'b0;
        chk("c_full_hold", 32'(ckpt_count), 32'd8);
        do_resolve(sb[0].pred, m);
        chk("c_reopen", 32'(predict_ready), 32'd1);
        do_both(16'h0090);
        while (sb.size() > 0) do_resolve(sb[0].pred, m);
        resolve_valid = 1'b1;
        resolve_outcome = 1'b1;
        #1;
        chk("c_empty_rready", 32'(resolve_ready), 32'd0);
        step();
        resolve_valid = 1'b0;
        chk("c_err_pulse", 32'(resolve_error), 32'd1);
        step();
        chk("c_err_clear", 32'(resolve_error), 32'd0);
        chk("c_empty_count", 32'(ckpt_count), 32'd0);

        // Mispredict on the oldest of three rolls back the younger two.
        do_predict(16'h0004, t);
        do_predict(16'h0008, t);
        do_predict(16'h000C, t);
        do_resolve(1'b1, m);
        chk("d_mis", 32'(m), 32'd1);
        chk("d_lht1", 32'(dut.lht_r[7'h01]), 32'h001);
        chk("d_lht2", 32'(dut.lht_r[7'h02]), 32'h000);
        chk("d_lht3", 32'(dut.lht_r[7'h03]), 32'h000);
        chk("d_count", 32'(ckpt_count), 32'd0);

        // Build history 0x155 on index 4, then repair same-index entries.
        pat = 10'h155;
        for (int b = 9; b >= 0; b--) begin
            do_predict(16'h0010, t);
            do_resolve(pat[b], m);
        end
        chk("e_lht_setup", 32'(dut.lht_r[7'h04]), 32'h155);
        do_predict(16'h0010, t);
        chk("e_pred1", 32'(t), 32'd0);
        do_predict(16'h0010, t);
        chk("e_pred2", 32'(t), 32'd0);
        do_resolve(1'b1, m);
        chk("e_mis", 32'(m), 32'd1);
        chk("e_lht", 32'(dut.lht_r[7'h04]), 32'h2AB);
        chk("e_count", 32'(ckpt_count), 32'd0);

        // Wider counters saturate at 7.
        for (int k = 0; k < 20; k++) begin
            pv3 = 1'b1;
            pc3 = 16'h0100;
            #1;
            chk("w_pready", 32'(pr3), 32'd1);
            step();
            pv3 = 1'b0;
            rv3 = 1'b1;
            ro3 = 1'b1;
            #1;
            chk("w_rready", 32'(rr3), 32'd1);
            step();
            rv3 = 1'b0;
            step();
            step();
        end
        chk("w_sat", 32'(dut3.pht_r[10'h3FF]), 32'd7);
        pv3 = 1'b1;
        #1;
        chk("w_taken", 32'(pt3), 32'd1);
        pv3 = 1'b0;

        // Reset asserted in the middle of a repair.
        do_predict(16'h0200, t);
        do_predict(16'h0204, t);
        do_predict(16'h0208, t);
        resolve_valid = 1'b1;
        resolve_outcome = ~sb[0].pred;
        step();
        resolve_valid = 1'b0;
        chk("f_in_repair", 32'(predict_ready), 32'd0);
        chk("f_rep_count", 32'(ckpt_count), 32'd2);
        step();
        reset = 1'b0;
        #1;
        chk("f_rst_done", 32'(init_done), 32'd0);
        chk("f_rst_count", 32'(ckpt_count), 32'd0);
        chk("f_rst_err", 32'(resolve_error), 32'd0);
        step();
        step();
        wait_init();
        do_predict(16'h0040, t);
        chk("f_taken", 32'(t), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
